// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - eight-word 64-bit data memory answering one request at a time with fixed wait states
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int NUM_WORDS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [63:0] element1,
    output logic [63:0] element2,
    output logic [63:0] element3,
    output logic [63:0] element4,
    output logic [63:0] element5,
    output logic [63:0] element6,
    output logic [63:0] element7,
    output logic [63:0] element8
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [63:0] mem_q [NUM_WORDS];
    logic [63:0] mem_d [NUM_WORDS];

    logic [2:0]  idx;
    logic        acc_err;

    // Only the captured address is ever decoded, so mid-transaction request changes are harmless.
    assign idx     = addr_q[5:3];
    assign acc_err = (addr_q[2:0] != 3'd0) || (addr_q[63:6] != 58'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        for (int i = 0; i < NUM_WORDS; i++) begin
            mem_d[i] = mem_q[i];
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    if (acc_err) begin
                        rdata_d = 64'd0;
                        err_d   = 1'b1;
                    end else if (wr_q) begin
                        mem_d[idx] = wdata_q;
                        rdata_d    = 64'd0;
                        err_d      = 1'b0;
                    end else begin
                        rdata_d = mem_q[idx];
                        err_d   = 1'b0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    assign element1 = mem_q[0];
    assign element2 = mem_q[1];
    assign element3 = mem_q[2];
    assign element4 = mem_q[3];
    assign element5 = mem_q[4];
    assign element6 = mem_q[5];
    assign element7 = mem_q[6];
    assign element8 = mem_q[7];

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_write, rsp_ready;
    logic [63:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [63:0] rsp_rdata;
    wire  [63:0] el [8];

    logic        req_valid0, req_write0, rsp_ready0;
    logic [63:0] req_addr0, req_wdata0;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [63:0] rsp_rdata0;
    wire  [63:0] el0 [8];

    logic [63:0] exp_mem [8];
    int          nvec;
    int          nerr;

    localparam logic [63:0] D1 = 64'hDEADBEEF_00000001;
    localparam logic [63:0] D0 = 64'h01234567_89ABCDEF;

    data_mem_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .element1(el[0]), .element2(el[1]), .element3(el[2]), .element4(el[3]),
        .element5(el[4]), .element6(el[5]), .element7(el[6]), .element8(el[7])
    );

    data_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst_n),
        .req_valid(req_valid0), .req_write(req_write0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
        .element1(el0[0]), .element2(el0[1]), .element3(el0[2]), .element4(el0[3]),
        .element5(el0[4]), .element6(el0[5]), .element7(el0[6]), .element8(el0[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_req(input logic wr, input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] exp_rd, input logic exp_err, input string nm);
        int n;
        @(negedge clk);
        nvec++;
        if (req_ready !== 1'b1) begin
            nerr++; $display("FAIL %s req_ready before request: got %b want 1", nm, req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_wdata = ~d;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        nvec++;
        if (n != 3) begin
            nerr++; $display("FAIL %s latency: got %0d edges want 3", nm, n);
        end
        nvec++;
        if (rsp_err !== exp_err) begin
            nerr++; $display("FAIL %s rsp_err: got %b want %b", nm, rsp_err, exp_err);
        end
        nvec++;
        if (rsp_rdata !== exp_rd) begin
            nerr++; $display("FAIL %s rsp_rdata: got %h want %h", nm, rsp_rdata, exp_rd);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        nvec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            nerr++; $display("FAIL %s after handshake: got valid=%b ready=%b want 0 1", nm, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nvec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL reset handshake outputs: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        nvec++;
        if (rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
            nerr++; $display("FAIL reset response: got rdata=%h err=%b want 0 0", rsp_rdata, rsp_err);
        end
        for (int i = 0; i < 8; i++) begin
            exp_mem[i] = 64'd0;
            nvec++;
            if (el[i] !== 64'd0) begin
                nerr++; $display("FAIL reset element%0d: got %h want 0", i + 1, el[i]);
            end
        end
    endtask

    task automatic test_store();
        do_req(1'b1, 64'h10, D1, 64'd0, 1'b0, "store_0x10");
        exp_mem[2] = D1;
        nvec++;
        if (el[2] !== D1) begin
            nerr++; $display("FAIL store element3: got %h want %h", el[2], D1);
        end
    endtask

    task automatic test_load();
        do_req(1'b0, 64'h10, 64'hFFFF, D1, 1'b0, "load_0x10");
        do_req(1'b0, 64'h38, 64'd0, 64'd0, 1'b0, "load_0x38");
    endtask

    task automatic test_error();
        do_req(1'b0, 64'h0C, 64'd0, 64'd0, 1'b1, "load_misaligned");
        do_req(1'b1, 64'h40, 64'hAAAA_5555, 64'd0, 1'b1, "store_out_of_range");
        do_req(1'b1, 64'h1_0000_0010, 64'hBAD, 64'd0, 1'b1, "store_high_addr");
        for (int i = 0; i < 8; i++) begin
            nvec++;
            if (el[i] !== exp_mem[i]) begin
                nerr++; $display("FAIL error element%0d: got %h want %h", i + 1, el[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_hold();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            req_valid = c[0];
            req_addr  = 64'h8 * 64'(c);
            @(negedge clk);
            nvec++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== D1 || rsp_err !== 1'b0) begin
                nerr++; $display("FAIL hold cycle %0d: got valid=%b ready=%b rdata=%h err=%b want 1 0 %h 0",
                                 c, rsp_valid, req_ready, rsp_rdata, rsp_err, D1);
            end
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        nvec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL hold release: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_resp();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        nvec++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== D1) begin
            nerr++; $display("FAIL reset_resp pre: got valid=%b rdata=%h want 1 %h", rsp_valid, rsp_rdata, D1);
        end
        rst_n = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 64'd0;
        nvec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_resp state: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        nvec++;
        if (rsp_rdata !== 64'd0 || el[2] !== 64'd0) begin
            nerr++; $display("FAIL reset_resp clear: got rdata=%h element3=%h want 0 0", rsp_rdata, el[2]);
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h08; req_wdata = 64'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nvec++;
        if (el[1] !== 64'd0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_busy: got element2=%h ready=%b valid=%b want 0 1 0", el[1], req_ready, rsp_valid);
        end
        repeat (4) @(negedge clk);
        nvec++;
        if (el[1] !== 64'd0 || rsp_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_busy late commit: got element2=%h valid=%b want 0 0", el[1], rsp_valid);
        end
        do_req(1'b0, 64'h08, 64'd0, 64'd0, 1'b0, "load_after_abort");
    endtask

    task automatic test_back_to_back();
        logic exp_rdy, exp_vld;
        @(negedge clk);
        req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 64'h18; req_wdata0 = D0;
        for (int s = 0; s < 9; s++) begin
            if (s > 0) @(negedge clk);
            exp_rdy = (s % 3 == 0);
            exp_vld = (s % 3 == 2);
            nvec++;
            if (req_ready0 !== exp_rdy || rsp_valid0 !== exp_vld) begin
                nerr++; $display("FAIL b2b sample %0d: got ready=%b valid=%b want %b %b",
                                 s, req_ready0, rsp_valid0, exp_rdy, exp_vld);
            end
            if (s == 1) begin
                req_write0 = 1'b0;
                req_wdata0 = 64'd0;
            end
            if (s == 2) begin
                nvec++;
                if (el0[3] !== D0 || rsp_rdata0 !== 64'd0 || rsp_err0 !== 1'b0) begin
                    nerr++; $display("FAIL b2b store: got element4=%h rdata=%h err=%b want %h 0 0",
                                     el0[3], rsp_rdata0, rsp_err0, D0);
                end
            end
            if (s == 5 || s == 8) begin
                nvec++;
                if (rsp_rdata0 !== D0 || rsp_err0 !== 1'b0) begin
                    nerr++; $display("FAIL b2b load %0d: got rdata=%h err=%b want %h 0", s, rsp_rdata0, rsp_err0, D0);
                end
            end
        end
        req_valid0 = 1'b0;
    endtask

    initial begin
        nvec = 0; nerr = 0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 64'd0; req_wdata0 = 64'd0; rsp_ready0 = 1'b1;
        test_reset();
        test_store();
        test_load();
        test_error();
        test_hold();
        test_reset_resp();
        test_reset_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: wait states between request acceptance and the memory access (0..15).
REQ-002 Parameter NUM_WORDS, fixed 8: number of 64-bit storage words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; when 0 at a rising clk edge the block resets.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  64  byte address.
REQ-008 req_wdata  input  64  store data.
REQ-009 req_ready  output  1  responder can accept a request.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator consumes the response.
REQ-012 rsp_rdata  output  64  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request was misaligned or out of range.
REQ-014 element1..element8  output  64 each  continuous view of storage words 0..7.

Function
REQ-015 States: IDLE, BUSY, RESP; req_ready = (state==IDLE); rsp_valid = (state==RESP).
REQ-016 IDLE: on req_valid=1, capture req_write, req_addr and req_wdata; load wait counter with WAIT_CYCLES; go to BUSY.
REQ-017 BUSY, counter>0: decrement the counter and stay in BUSY.
REQ-018 BUSY, counter==0: perform the access at this edge and go to RESP.
REQ-019 Latency: rsp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge; WAIT_CYCLES=0 gives 1 edge.
REQ-020 Word index = captured addr[5:3].
REQ-021 Error condition: addr[2:0]!=0 or addr>=64.
REQ-022 Valid store: write the captured wdata to the word; rsp_rdata=0; rsp_err=0.
REQ-023 Valid load: rsp_rdata = word contents at the access edge; rsp_err=0.
REQ-024 Error: no storage change; rsp_rdata=0; rsp_err=1.
REQ-025 RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then return to IDLE at that edge.
REQ-026 Back-to-back: the earliest next acceptance is the edge after the response handshake (one IDLE cycle minimum).
REQ-027 req_valid is ignored outside IDLE; rsp_ready is ignored outside RESP.
REQ-028 Request fields change while in BUSY or RESP: no effect; only the captured copies are used.
REQ-029 element1..element8 are combinational from storage and show a store on the cycle after its access edge.

Reset
REQ-030 On reset=0 at an edge: state=IDLE, counter=0, all storage words=0, rsp_rdata=0, rsp_err=0.
REQ-031 Resulting outputs: req_ready=1, rsp_valid=0, element1..8=0.
REQ-032 Reset while in BUSY abandons the transaction; a pending store is never committed.
REQ-033 Reset while in RESP drops the response without a handshake.
REQ-034 Reset dominates a simultaneous req_valid or rsp_ready.

Verification
REQ-035 WAIT_CYCLES=2: store addr 0x10, data 0xDEADBEEF_00000001, rsp_ready=1 -> rsp_valid on 3rd edge after acceptance, rsp_err=0, element3=0xDEADBEEF_00000001 next cycle.
REQ-036 Load addr 0x10 after the store in REQ-035 -> rsp_rdata=0xDEADBEEF_00000001, rsp_err=0.
REQ-037 Load addr 0x0C and then store addr 0x40 -> rsp_err=1 and rsp_rdata=0 for both; all elements unchanged.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid and req_addr -> rsp_valid and rsp_rdata stable, req_ready=0; IDLE one edge after rsp_ready=1.
REQ-039 Store 0x55 to addr 0x08, assert reset=0 while in BUSY -> element2=0, req_ready=1, rsp_valid=0; a later load of 0x08 returns 0.
REQ-040 WAIT_CYCLES=0: back-to-back loads with rsp_ready tied 1 -> each response 1 edge after acceptance, acceptances 3 edges apart.
